// File: rtl/round_div_arbiter.sv
// Round-robin arbiter sharing one registered round-half-up divide-by-2^DIV_LOG2 stage.
// Optional ROUND_DIV_ARB_SAT_CNT_EN adds a saturating count of saturated results.
module round_div_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DIV_LOG2 = 3,
   parameter int OUT_WIDTH = 32,
   localparam int IN_WIDTH = OUT_WIDTH + DIV_LOG2,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0] req_ready,
   output logic out_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [ID_W-1:0] out_id,
   input  logic out_ready,
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
   output logic [15:0] sat_cnt,
`endif
   output logic busy
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] gnt_id;
   logic [ID_W-1:0] ptr_nxt;
   logic [NUM_REQ-1:0] gnt;
   logic found;
   logic load;
   logic xfer;
   logic [OUT_WIDTH-1:0] q;
   logic r;
   logic [OUT_WIDTH:0] s;
   logic sat;
   logic [OUT_WIDTH-1:0] res;

   // resetn gates load so nothing is offered while reset is held
   assign load = resetn & enable & (~out_valid | out_ready);

   always_comb begin
      gnt = '0;
      gnt_id = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt_id = ID_W'(idx);
            gnt[idx] = 1'b1;
         end
      end
   end

   assign req_ready = load ? gnt : '0;
   assign xfer = load & found;
   assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

   assign q = req_data[int'(gnt_id) * IN_WIDTH + DIV_LOG2 +: OUT_WIDTH];
   assign r = req_data[int'(gnt_id) * IN_WIDTH + DIV_LOG2 - 1];
   assign s = {1'b0, q} + {{OUT_WIDTH{1'b0}}, r};
   assign sat = s[OUT_WIDTH];
   assign res = sat ? q : s[OUT_WIDTH-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_id <= '0;
      end else if (xfer) begin
         ptr <= ptr_nxt;
         out_valid <= 1'b1;
         out_data <= res;
         out_id <= gnt_id;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ROUND_DIV_ARB_SAT_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sat_cnt <= '0;
      end else if (xfer && sat && sat_cnt != 16'hFFFF) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

   assign busy = out_valid | (|req_valid);

endmodule

// File: tb/tb_round_div_arbiter.sv
// Directed bench for round_div_arbiter with a result scoreboard.
// Honours ROUND_DIV_ARB_SAT_CNT_EN when the design is built with it.
module tb_round_div_arbiter;

   logic clk = 1'b0;
   logic resetn;
   logic enable;
   logic [3:0] req_valid;
   logic [34:0] d [4];
   logic [139:0] req_data;
   logic [3:0] req_ready;
   logic out_valid;
   logic [31:0] out_data;
   logic [1:0] out_id;
   logic out_ready;
   logic busy;
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
   logic [15:0] sat_cnt;
   int exp_sat;
`endif

   typedef struct {
      int id;
      logic [31:0] v;
   } exp_t;

   exp_t sb [$];
   int tb_ptr;
   int n_tests;
   int n_fail;

   assign req_data = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   round_div_arbiter dut (
      .clk(clk),
      .resetn(resetn),
      .enable(enable),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_id(out_id),
      .out_ready(out_ready),
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
      .sat_cnt(sat_cnt),
`endif
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fm(input logic [34:0] x);
      logic [35:0] t;
      if (x[34:3] == 32'hFFFFFFFF) return 32'hFFFFFFFF;
      t = {1'b0, x} + 36'd4;
      return t[34:3];
   endfunction

   // one clock: check outputs mid-cycle, update scoreboard, advance
   task automatic cycle(input string tag);
      logic exp_ov;
      logic load_m;
      logic [3:0] exp_rdy;
      int g;
      exp_t e;
      @(negedge clk);
      exp_ov = (sb.size() != 0);
      load_m = resetn && enable && (!exp_ov || out_ready);
      g = -1;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (tb_ptr + k) % 4;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = (load_m && g >= 0) ? 4'(1 << g) : 4'd0;
      chk({tag, "_rdy"}, 64'(req_ready), 64'(exp_rdy));
      chk({tag, "_ov"}, 64'(out_valid), 64'(exp_ov));
      chk({tag, "_busy"}, 64'(busy), 64'(exp_ov || (|req_valid)));
      if (exp_ov) begin
         chk({tag, "_data"}, 64'(out_data), 64'(sb[0].v));
         chk({tag, "_id"}, 64'(out_id), 64'(sb[0].id));
         if (out_ready) void'(sb.pop_front());
      end
      if (exp_rdy != 4'd0) begin
         e.id = g;
         e.v = fm(d[g]);
         sb.push_back(e);
         tb_ptr = (g + 1) % 4;
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
         if (d[g][34:2] == 33'h1FFFFFFFF && exp_sat < 65535) exp_sat++;
`endif
      end
      @(posedge clk);
      #1;
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
      chk({tag, "_satcnt"}, 64'(sat_cnt), 64'(exp_sat));
`endif
   endtask

   task automatic do_reset(input string tag);
      resetn = 1'b0;
      #1;
      sb.delete();
      tb_ptr = 0;
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
      exp_sat = 0;
`endif
      chk({tag, "_rst_ov"}, 64'(out_valid), 64'd0);
      chk({tag, "_rst_rdy"}, 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      tb_ptr = 0;
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
      exp_sat = 0;
`endif
      resetn = 1'b1;
      enable = 1'b1;
      out_ready = 1'b1;
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) d[i] = '0;
      #1;
      resetn = 1'b0;
      #1;
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_id", 64'(out_id), 64'd0);
      chk("rst_rdy", 64'(req_ready), 64'd0);
      req_valid = 4'h0;
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // single requester, rounding up and down
      req_valid = 4'b0010;
      d[1] = 35'h14;
      cycle("t1a");
      d[1] = 35'h13;
      cycle("t1b");
      req_valid = 4'b0000;
      cycle("t1c");
      cycle("t1d");

      // all requesters valid from reset: ids 0,1,2,3,0
      do_reset("t2");
      for (int i = 0; i < 4; i++) d[i] = 35'(i * 16 + 5);
      req_valid = 4'hF;
      for (int i = 0; i < 5; i++) cycle("t2");

      // stall three cycles, then pop and transfer together
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) cycle("t4stall");
      out_ready = 1'b1;
      cycle("t4rel");
      cycle("t4post");

      // async reset with ptr at 2 and a held result
      do_reset("t5pre");
      cycle("t5a");
      cycle("t5b");
      resetn = 1'b0;
      #1;
      chk("t5_async_ov", 64'(out_valid), 64'd0);
      chk("t5_async_rdy", 64'(req_ready), 64'd0);
      chk("t5_async_id", 64'(out_id), 64'd0);
      sb.delete();
      tb_ptr = 0;
`ifdef ROUND_DIV_ARB_SAT_CNT_EN
      exp_sat = 0;
`endif
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cycle("t5c");
      cycle("t5d");

      // saturation and the non-saturating all-ones result
      req_valid = 4'b0001;
      d[0] = {35{1'b1}};
      cycle("t3a");
      d[0] = 35'h7FFFFFFFB;
      cycle("t3b");
      d[0] = 35'h7FFFFFFFC;
      cycle("t3c");
      req_valid = 4'b0000;
      cycle("t3d");
      cycle("t3e");

      // enable low: held result drains, no new grants
      req_valid = 4'hF;
      out_ready = 1'b0;
      cycle("t6a");
      enable = 1'b0;
      cycle("t6b");
      out_ready = 1'b1;
      cycle("t6c");
      cycle("t6d");
      cycle("t6e");
      enable = 1'b1;
      cycle("t6f");
      req_valid = 4'h0;
      cycle("t6g");
      cycle("t6h");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
